inv_key_schedule: RTL and testbench

INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

---
 rtl/inv_key_schedule_if.sv | 24 ++
 rtl/inv_key_schedule.sv | 158 +++++++++++++++
 tb/tb_inv_key_schedule.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/inv_key_schedule_if.sv
// Handshake bundle for the AES-128 inverse key schedule: key request on one
// side, round-key stream (10 down to 0) on the other.
interface inv_key_schedule_if;
  logic           start;
  logic [0:127]   key;
  logic           busy;
  logic           rk_valid;
  logic           rk_ready;
  logic [0:127]   rk;
  logic [3:0]     rk_round;
  logic           done;

  // Requester / round-key consumer side.
  modport master (
    output start, key, rk_ready,
    input  busy, rk_valid, rk, rk_round, done
  );

  // Key schedule side.
  modport slave (
    input  start, key, rk_ready,
    output busy, rk_valid, rk, rk_round, done
  );
endinterface

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule. A start expands the cipher key forward to
// round key 10, then streams round keys 10..0 over a valid/ready handshake,
// rebuilding each earlier key from the current one on every transfer.
module inv_key_schedule (
  input  logic              clk,
  input  logic              rst_n,
  inv_key_schedule_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, OUT = 2'd2} state_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  // S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [31:0] rcon(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

  state_t         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [3:0]     round_q, round_d;
  logic [127:0]   rk_q;
  logic [3:0]     rk_round_q;
  logic           done_q, done_d;
  logic           load_rk;

  // Working key words and the shared S-box path. Forward expansion feeds w3
  // through RotWord/SubWord with Rcon(r+1); the inverse step feeds p3 with
  // Rcon(r). Both then produce word 0 as w0 ^ SubWord(RotWord(.)) ^ Rcon.
  logic [31:0]    w0, w1, w2, w3;
  logic [31:0]    p1, p2, p3;
  logic [31:0]    f1, f2, f3;
  logic [31:0]    sw_in, new_w0;
  logic [3:0]     rcon_idx;
  logic [127:0]   key_fwd, key_bwd;

  assign {w0, w1, w2, w3} = key_q;
  assign p3       = w3 ^ w2;
  assign p2       = w2 ^ w1;
  assign p1       = w1 ^ w0;
  assign sw_in    = (state_q == FWD) ? w3 : p3;
  assign rcon_idx = (state_q == FWD) ? round_q + 4'd1 : round_q;
  assign new_w0   = w0 ^ sub_rot_word(sw_in) ^ rcon(rcon_idx);
  assign f1       = new_w0 ^ w1;
  assign f2       = f1 ^ w2;
  assign f3       = f2 ^ w3;
  assign key_fwd  = {new_w0, f1, f2, f3};
  assign key_bwd  = {new_w0, p1, p2, p3};

  // Next-state, working-key and round-counter logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    load_rk = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          key_d   = bus.key;
          round_d = 4'd0;
          state_d = FWD;
        end
      end
      FWD: begin
        // Ten expansion steps bring r to 10; the cycle that sees r == 10
        // publishes K(10) as the first round key.
        if (round_q == LAST_ROUND) begin
          state_d = OUT;
          load_rk = 1'b1;
        end else begin
          key_d   = key_fwd;
          round_d = round_q + 4'd1;
        end
      end
      OUT: begin
        if (bus.rk_ready) begin
          if (round_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = key_bwd;
            round_d = round_q - 4'd1;
            load_rk = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, working key and output registers; rk holds outside OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q    <= IDLE;
      key_q      <= '0;
      round_q    <= '0;
      rk_q       <= '0;
      rk_round_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
      if (load_rk) begin
        rk_q       <= key_d;
        rk_round_q <= round_d;
      end
    end
  end

  // All outputs come from registers, so rk_ready never reaches them
  // combinationally.
  assign bus.busy     = (state_q != IDLE);
  assign bus.rk_valid = (state_q == OUT);
  assign bus.rk       = rk_q;
  assign bus.rk_round = rk_round_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed and randomised checks of inv_key_schedule against an independent
// forward key-expansion model whose S-box is derived from GF(2^8) arithmetic.
module tb_inv_key_schedule;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  inv_key_schedule_if bus ();

  inv_key_schedule dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] ref_rk [11];
  logic [127:0] obs_rk [11];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b};
    return t[15-n -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t ^= {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Entered and left 1 time unit after a rising edge (or at a falling edge);
  // the start is accepted on the next rising edge.
  task automatic start_key(input logic [127:0] k);
    bus.start = 1'b1;
    bus.key   = k;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.key   = rand_key();
  endtask

  // Starts an expansion of k and collects all 11 round keys. mode 0 keeps
  // rk_ready high; mode 1 toggles it randomly and pulses a stray start with
  // a different key during FWD and during OUT. Returns in the done cycle.
  task automatic run_seq(input logic [127:0] k, input int mode, input string tag);
    int          c;
    int          cyc;
    int          exp_r;
    logic        stalled;
    logic        rdy;
    logic [127:0] held_rk;
    logic [3:0]  held_r;
    expand_model(k);
    bus.rk_ready = (mode == 0);
    start_key(k);
    check({tag, " busy"}, 128'(bus.busy), 128'(1));
    c = 0;
    while (c < 20) begin
      @(posedge clk); #1;
      c++;
      if (bus.rk_valid) break;
      check({tag, " no done"}, 128'(bus.done), 128'(0));
      if (mode == 1) begin
        bus.start = (c == 4);
        bus.key   = ~k;
      end
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 128'(c), 128'(11));

    exp_r   = 10;
    cyc     = 0;
    stalled = 1'b0;
    held_rk = '0;
    held_r  = '0;
    rdy     = 1'b1;
    while (exp_r >= 0 && cyc < 300) begin
      if (bus.rk_valid) begin
        if (stalled) begin
          check({tag, " stall rk"}, bus.rk, held_rk);
          check({tag, " stall round"}, 128'(bus.rk_round), 128'(held_r));
        end
        check({tag, " round"}, 128'(bus.rk_round), 128'(exp_r));
        check({tag, " rk"}, bus.rk, ref_rk[exp_r]);
        held_rk = bus.rk;
        held_r  = bus.rk_round;
        rdy     = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        stalled = !rdy;
        if (rdy) begin
          obs_rk[exp_r] = bus.rk;
          exp_r--;
        end
      end else begin
        check({tag, " valid held"}, 128'(bus.rk_valid), 128'(1));
        rdy     = 1'b1;
        stalled = 1'b0;
      end
      bus.rk_ready = rdy;
      if (mode == 1) begin
        bus.start = (cyc == 3);
        bus.key   = ~k;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    check({tag, " all delivered"}, 128'(exp_r < 0), 128'(1));
    check({tag, " done"}, 128'(bus.done), 128'(1));
    check({tag, " idle valid"}, 128'(bus.rk_valid), 128'(0));
    check({tag, " idle busy"}, 128'(bus.busy), 128'(0));
    check({tag, " hold rk"}, bus.rk, ref_rk[0]);
    check({tag, " hold round"}, 128'(bus.rk_round), 128'(0));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " busy"}, 128'(bus.busy), 128'(0));
    check({tag, " valid"}, 128'(bus.rk_valid), 128'(0));
    check({tag, " rk"}, bus.rk, 128'(0));
    check({tag, " round"}, 128'(bus.rk_round), 128'(0));
    check({tag, " done"}, 128'(bus.done), 128'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k;
    int           c;
    bus.start    = 1'b0;
    bus.key      = '0;
    bus.rk_ready = 1'b0;
    build_sbox();

    // Reset state, then the first start lands on the first edge after release.
    #12;
    check_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(FIPS_KEY, 0, "fips");
    check("fips round10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("fips round1",  obs_rk[1],  128'ha0fafe1788542cb123a339392a6c7605);
    check("fips round0",  obs_rk[0],  FIPS_KEY);

    // Start accepted in the done cycle.
    run_seq(SEQ_KEY, 0, "chain");
    check("chain round10", obs_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    @(posedge clk); #1;
    check("done width", 128'(bus.done), 128'(0));

    // Backpressure with stray starts during FWD and OUT.
    run_seq(rand_key(), 1, "bp_a");
    run_seq(128'hffffffffffffffffffffffffffffffff, 1, "bp_b");

    // Asynchronous reset in OUT at round 5, then a clean restart.
    k = rand_key();
    expand_model(k);
    bus.rk_ready = 1'b1;
    start_key(k);
    c = 0;
    while (!(bus.rk_valid && bus.rk_round == 4'd5) && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    check("rst at r5 round", 128'(bus.rk_round), 128'(5));
    check("rst at r5 rk", bus.rk, ref_rk[5]);
    bus.rk_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("async rst");
    @(posedge clk); @(posedge clk); #1;
    check_cleared("rst held");
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(rand_key(), 0, "post_rst");

    // Random keys, each started in the previous done cycle.
    for (int i = 0; i < 1000; i++) run_seq(rand_key(), 0, "rnd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
